// File: rtl/issue_scoreboard_pkg.sv
// Shared parameters, types and helpers for the in-order issue scoreboard.
package issue_scoreboard_pkg;

  localparam int unsigned ALU_WB_LAT = 2;
  localparam int unsigned MUL_WB_LAT = 7;
  localparam int unsigned BYP_AHEAD  = 1;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned NREG       = 32;
  localparam int unsigned PERF_W     = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_STRUCT
  } hz_cause_e;

  // Saturating increment for the hazard statistics counters.
  function automatic logic [PERF_W-1:0] sat_inc(logic [PERF_W-1:0] v, logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake bundle plus scoreboard status outputs.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic                  dec_valid_i;
  logic                  dec_is_mult_i;
  logic                  dec_wr_en_i;
  reg_idx_t              dec_rd_i;
  reg_idx_t              dec_rs1_i;
  logic                  dec_rs1_used_i;
  reg_idx_t              dec_rs2_i;
  logic                  dec_rs2_used_i;
  logic                  freeze_i;
  logic                  flush_i;
  logic                  issue_o;
  logic                  stall_o;
  logic [NREG-1:0]       pending_o;
  logic [MUL_WB_LAT-1:0] wb_busy_o;

  modport master (
    output dec_valid_i, dec_is_mult_i, dec_wr_en_i, dec_rd_i,
           dec_rs1_i, dec_rs1_used_i, dec_rs2_i, dec_rs2_used_i,
           freeze_i, flush_i,
    input  issue_o, stall_o, pending_o, wb_busy_o
  );

  modport slave (
    input  dec_valid_i, dec_is_mult_i, dec_wr_en_i, dec_rd_i,
           dec_rs1_i, dec_rs1_used_i, dec_rs2_i, dec_rs2_used_i,
           freeze_i, flush_i,
    output issue_o, stall_o, pending_o, wb_busy_o
  );

endinterface

// File: rtl/issue_scoreboard_reg_counter.sv
// One register's writeback countdown: load on issue, count down, hold on freeze.
module scb_reg_counter
  import issue_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rsn,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             pending
);

  // A new issue to this register overrides the in-flight decrement.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard for the ALU/multiplier datapath sharing one writeback port.
// Optional hazard statistics outputs are enabled with SCB_PERF_EN.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rsn_i,
  issue_scoreboard_if.slave bus
`ifdef SCB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_raw_o,
  output logic [PERF_W-1:0] perf_waw_o,
  output logic [PERF_W-1:0] perf_struct_o
`endif
);

  logic [CNT_W-1:0]      cnt [NREG];
  logic [NREG-1:0]       pending;
  logic [MUL_WB_LAT:1]   wb_busy;
  logic [MUL_WB_LAT:1]   wb_busy_nxt;
  logic [CNT_W-1:0]      lat;
  logic [3:1]            hz_vec;
  logic                  hz;
  logic                  issue;
  logic                  stall;
  logic                  reserve;

  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    scb_reg_counter u_cnt (
      .clk      (clk_i),
      .rsn      (rsn_i),
      .freeze   (bus.freeze_i),
      .load     (reserve && (bus.dec_rd_i == reg_idx_t'(r))),
      .load_val (lat - CNT_W'(1)),
      .cnt      (cnt[r]),
      .pending  (pending[r])
    );
  end

  // RAW waits only until the producer is on the bypass network.
  always_comb begin
    lat    = bus.dec_is_mult_i ? CNT_W'(MUL_WB_LAT) : CNT_W'(ALU_WB_LAT);
    hz_vec = '0;
    if (bus.dec_valid_i) begin
      hz_vec[HZ_RAW]    = (bus.dec_rs1_used_i && (bus.dec_rs1_i != '0) &&
                           (cnt[bus.dec_rs1_i] > CNT_W'(BYP_AHEAD))) ||
                          (bus.dec_rs2_used_i && (bus.dec_rs2_i != '0) &&
                           (cnt[bus.dec_rs2_i] > CNT_W'(BYP_AHEAD)));
      hz_vec[HZ_WAW]    = bus.dec_wr_en_i && (bus.dec_rd_i != '0) &&
                          (cnt[bus.dec_rd_i] >= lat);
      hz_vec[HZ_STRUCT] = bus.dec_wr_en_i && wb_busy[lat];
    end
  end

  assign hz      = |hz_vec;
  assign issue   = bus.dec_valid_i && !hz && !bus.freeze_i && !bus.flush_i;
  assign stall   = bus.dec_valid_i && hz && !bus.flush_i;
  assign reserve = issue && bus.dec_wr_en_i;

  // Writeback-slot reservations slide one slot closer every unfrozen cycle.
  always_comb begin
    wb_busy_nxt = wb_busy >> 1;
    if (reserve) begin
      wb_busy_nxt[lat - CNT_W'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      wb_busy <= '0;
    end else if (!bus.freeze_i) begin
      wb_busy <= wb_busy_nxt;
    end
  end

  assign bus.issue_o   = issue;
  assign bus.stall_o   = stall;
  assign bus.pending_o = pending;
  assign bus.wb_busy_o = wb_busy;

`ifdef SCB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      perf_raw_o    <= '0;
      perf_waw_o    <= '0;
      perf_struct_o <= '0;
    end else if (!bus.freeze_i) begin
      perf_raw_o    <= sat_inc(perf_raw_o,    stall && hz_vec[HZ_RAW]);
      perf_waw_o    <= sat_inc(perf_waw_o,    stall && hz_vec[HZ_WAW]);
      perf_struct_o <= sat_inc(perf_struct_o, stall && hz_vec[HZ_STRUCT]);
    end
  end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: absolute-time writeback model plus directed hazard scenarios.
module tb_issue_scoreboard;

  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 7;
  localparam int BYP     = 1;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_if bus ();

`ifdef SCB_PERF_EN
  logic [31:0] perf_raw, perf_waw, perf_struct;
`endif

  issue_scoreboard dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
`ifdef SCB_PERF_EN
    ,
    .perf_raw_o    (perf_raw),
    .perf_waw_o    (perf_waw),
    .perf_struct_o (perf_struct)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: virtual time advances on every unfrozen edge; each register keeps
  // the absolute time of its last scheduled writeback, each slot is a set entry.
  int vt = 0;
  int wb_time [32];
  bit resv [int];
  bit model_ok = 1'b0;

  function automatic int m_cnt(int r);
    int d;
    if (r == 0) return 0;
    d = wb_time[r] - vt;
    return (d > 0) ? d : 0;
  endfunction

  function automatic bit m_busy(int k);
    return resv.exists(vt + k);
  endfunction

  function automatic void m_eval(output bit iss, output bit stl, output int lat);
    bit raw, waw, st, hz;
    lat = bus.dec_is_mult_i ? MUL_LAT : ALU_LAT;
    raw = (bus.dec_rs1_used_i && bus.dec_rs1_i != 0 && m_cnt(int'(bus.dec_rs1_i)) > BYP) ||
          (bus.dec_rs2_used_i && bus.dec_rs2_i != 0 && m_cnt(int'(bus.dec_rs2_i)) > BYP);
    waw = bus.dec_wr_en_i && bus.dec_rd_i != 0 && m_cnt(int'(bus.dec_rd_i)) >= lat;
    st  = bus.dec_wr_en_i && m_busy(lat);
    hz  = bus.dec_valid_i && (raw || waw || st);
    iss = bus.dec_valid_i && !hz && !bus.freeze_i && !bus.flush_i;
    stl = hz && !bus.flush_i;
  endfunction

  always @(posedge clk) begin
    bit iss, stl;
    int lat;
    if (!rsn) begin
      vt = 0;
      foreach (wb_time[r]) wb_time[r] = 0;
      resv.delete();
      model_ok = 1'b1;
    end else if (model_ok && !bus.freeze_i) begin
      m_eval(iss, stl, lat);
      if (iss && bus.dec_wr_en_i) begin
        if (bus.dec_rd_i != 0) wb_time[int'(bus.dec_rd_i)] = vt + lat;
        resv[vt + lat] = 1'b1;
      end
      vt++;
    end
  end

  always @(negedge clk) begin
    bit iss, stl;
    int lat;
    logic [31:0] ep;
    logic [6:0]  eb;
    if (model_ok && rsn) begin
      m_eval(iss, stl, lat);
      for (int r = 0; r < 32; r++) ep[r] = (m_cnt(r) > 0);
      for (int k = 1; k <= 7; k++) eb[k-1] = m_busy(k);
      check("model_issue",   32'(bus.issue_o),   32'(iss));
      check("model_stall",   32'(bus.stall_o),   32'(stl));
      check("model_pending", bus.pending_o,      ep);
      check("model_wb_busy", 32'(bus.wb_busy_o), 32'(eb));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int v, int mult, int wr, int rd, int rs1, int u1, int rs2, int u2);
    bus.dec_valid_i    = 1'(v);
    bus.dec_is_mult_i  = 1'(mult);
    bus.dec_wr_en_i    = 1'(wr);
    bus.dec_rd_i       = 5'(rd);
    bus.dec_rs1_i      = 5'(rs1);
    bus.dec_rs1_used_i = 1'(u1);
    bus.dec_rs2_i      = 5'(rs2);
    bus.dec_rs2_used_i = 1'(u2);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts stall cycles until issue, bounded; leaves time inside the issuing cycle.
  task automatic count_stalls(string name, output int n);
    bit got;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (bus.issue_o) begin
        got = 1'b1;
        break;
      end
      if (bus.stall_o) n++;
      tick();
    end
    check(name, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.freeze_i = 1'b0;
    bus.flush_i  = 1'b0;
    idle();
    rsn = 1'b0;
    tick();
    tick();
    rsn = 1'b1;
    #3;
    check("rst_pending", bus.pending_o, 32'h0);
    check("rst_wb_busy", 32'(bus.wb_busy_o), 32'h0);
    check("rst_issue",   32'(bus.issue_o), 32'd0);
    check("rst_stall",   32'(bus.stall_o), 32'd0);

    // First ALU write to r5
    drive(1, 0, 1, 5, 0, 0, 0, 0);
    #3;
    check("alu_issue", 32'(bus.issue_o), 32'd1);
    check("alu_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #3;
    check("alu_pending", bus.pending_o, 32'h20);
    check("alu_wb_busy", 32'(bus.wb_busy_o), 32'h01);
    tick();
    #3;
    check("alu_retired", bus.pending_o, 32'h0);

    // Back-to-back dependent ALU ops go through the bypass
    drive(1, 0, 1, 1, 0, 0, 0, 0);
    #3;
    check("b2b_first", 32'(bus.issue_o), 32'd1);
    tick();
    drive(1, 0, 1, 2, 1, 1, 0, 0);
    #3;
    check("b2b_second", 32'(bus.issue_o), 32'd1);
    tick();
    drain(3);

    // MUL then dependent ADD: five RAW stalls
    drive(1, 1, 1, 3, 0, 0, 0, 0);
    #3;
    check("mul_issue", 32'(bus.issue_o), 32'd1);
    tick();
    drive(1, 0, 1, 10, 3, 1, 0, 0);
    count_stalls("raw_issued", n);
    check("raw_stalls", 32'(n), 32'd5);
    tick();
    idle();
`ifdef SCB_PERF_EN
    #3;
    check("perf_raw",    perf_raw,    32'd5);
    check("perf_waw",    perf_waw,    32'd0);
    check("perf_struct", perf_struct, 32'd0);
`endif
    drain(8);

    // Writeback-port conflict between MUL and a later ALU
    drive(1, 1, 1, 4, 0, 0, 0, 0);
    tick();
    drain(4);
    drive(1, 0, 1, 7, 0, 0, 0, 0);
    #3;
    check("struct_stall",   32'(bus.stall_o), 32'd1);
    check("struct_noissue", 32'(bus.issue_o), 32'd0);
    check("struct_slot2",   32'(bus.wb_busy_o), 32'h02);
    tick();
    #3;
    check("struct_issue", 32'(bus.issue_o), 32'd1);
    tick();
`ifdef SCB_PERF_EN
    idle();
    #3;
    check("perf_struct1", perf_struct, 32'd1);
    check("perf_raw1",    perf_raw,    32'd5);
`endif
    drain(8);

    // WAW: ALU to r9 waits behind the MUL to r9
    drive(1, 1, 1, 9, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 9, 0, 0, 0, 0);
    count_stalls("waw_issued", n);
    check("waw_stalls", 32'(n), 32'd5);
    tick();
    drain(8);

    // Freeze while a RAW stall is pending
    drive(1, 1, 1, 2, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 13, 0, 0, 2, 1);
    #3;
    check("frz_first_stall", 32'(bus.stall_o), 32'd1);
    tick();
    bus.freeze_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("frz_pending", bus.pending_o, 32'h4);
      check("frz_wb_busy", 32'(bus.wb_busy_o), 32'h10);
      check("frz_stall",   32'(bus.stall_o), 32'd1);
      tick();
    end
    bus.freeze_i = 1'b0;
    count_stalls("frz_issued", n);
    check("frz_stalls", 32'(n + 5), 32'd9);
    tick();
    drain(8);

    // Flush kills a hazarded instruction without touching state
    drive(1, 1, 1, 6, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 12, 6, 1, 0, 0);
    bus.flush_i = 1'b1;
    #3;
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    check("flush_issue", 32'(bus.issue_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    #3;
    check("flush_pending", bus.pending_o, 32'h40);
    count_stalls("flush_issued", n);
    check("flush_stalls", 32'(n), 32'd4);
    tick();
    drain(8);

    // Writes to r0 reserve a slot but are never tracked
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    #3;
    check("r0_pending", bus.pending_o, 32'h0);
    check("r0_wb_busy", 32'(bus.wb_busy_o), 32'h20);
    drain(8);

    // No-write instruction ignores WAW; then reset mid-flight
    drive(1, 1, 1, 11, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 11, 0, 0, 0, 0);
    #3;
    check("nowr_issue", 32'(bus.issue_o), 32'd1);
    tick();
    idle();
    rsn = 1'b0;
    tick();
    rsn = 1'b1;
    #3;
    check("midrst_pending", bus.pending_o, 32'h0);
    check("midrst_wb_busy", 32'(bus.wb_busy_o), 32'h0);
    drain(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order issue controller between decoder and execute for the dual-latency datapath: single-cycle ALU path and multi-stage multiplier path (exe + mult1..mult5) sharing one integer writeback port.
- Tracks per-register pending writebacks and writeback-slot occupancy.
- Issues a decoded instruction only when it has no RAW, WAW or writeback-port hazard; otherwise stalls decode.
- Complements bypass control: stalls only when the bypass network cannot yet supply the operand.

Parameters:
ALU_WB_LAT, 2, cycles from issue decision cycle to ALU writeback cycle
MUL_WB_LAT, 7, cycles from issue decision cycle to multiplier writeback cycle (must exceed ALU_WB_LAT)
BYP_AHEAD, 1, cycles before writeback that a result becomes visible on the bypass network
CNT_W, 3, per-register countdown width; must hold MUL_WB_LAT

Ports:
clk_i  in  1  clock
rsn_i  in  1  synchronous active-low reset
dec_valid_i  in  1  decode holds a valid instruction
dec_is_mult_i  in  1  instruction uses the multiplier path
dec_wr_en_i  in  1  instruction writes an integer register
dec_rd_i  in  5  destination register
dec_rs1_i  in  5  source A
dec_rs1_used_i  in  1  source A is read
dec_rs2_i  in  5  source B
dec_rs2_used_i  in  1  source B is read
freeze_i  in  1  whole-pipeline freeze (e.g. cache miss)
flush_i  in  1  kill instruction in decode
issue_o  out  1  instruction advances to execute this cycle
stall_o  out  1  decode must hold (hazard)
pending_o  out  32  bit r set while register r has an outstanding writeback
wb_busy_o  out  MUL_WB_LAT  writeback-slot reservation vector

Behaviour:
- Clock is clk_i; reset is rsn_i, synchronous and active-low. Both are fixed.
- Reset (rsn_i=0 at a rising edge): all counters cnt[0..31]=0 and wb_busy=0. issue_o and stall_o are combinational, so they read 0 while dec_valid_i=0. pending_o=0 and wb_busy_o=0 after the edge.
- A reset asserted mid-operation discards all in-flight tracking; no drain.
- lat = dec_is_mult_i ? MUL_WB_LAT : ALU_WB_LAT.
- cnt[r]: cycles from the current cycle until r's writeback; 0 means none pending.
- wb_busy[k] (k=1..MUL_WB_LAT): a writeback occurs k cycles from now.
- Hazards (combinational), only when dec_valid_i=1:
  - raw = (rs1_used & rs1!=0 & cnt[rs1]>BYP_AHEAD) | same for rs2.
  - waw = wr_en & rd!=0 & cnt[rd]>=lat.
  - struct = wr_en & wb_busy[lat].
  - hz = raw | waw | struct.
- issue_o = dec_valid_i & ~hz & ~freeze_i & ~flush_i.
- stall_o = dec_valid_i & hz & ~flush_i.
- Rising edge, freeze_i=1: all state held.
- Rising edge, freeze_i=0:
  - wb_busy <= (wb_busy>>1) | (issue_o & wr_en ? bit (lat-1) : 0).
  - Every nonzero cnt decrements by 1.
  - If issue_o & wr_en & rd!=0: cnt[rd] <= lat-1. The load wins over a simultaneous decrement of the same register.
- Register 0 is never tracked; cnt[0] is constantly 0.
- Instructions with wr_en=0 are checked for RAW only and reserve nothing.
- flush_i has priority over hazards: no issue, no stall, and no state change from the killed instruction. In-flight entries keep counting down.
- freeze_i together with a hazard: stall_o=1 and issue_o=0.
- Countdown reaching 0 clears pending_o[r] on the same edge the writeback completes.
- Throughput: back-to-back ALU issue is hazard-free. A MUL followed by a dependent instruction stalls MUL_WB_LAT-1-BYP_AHEAD = 5 cycles.

Optional Feature:
- Macro SCB_PERF_EN.
- Defined: adds outputs perf_raw_o[31:0], perf_waw_o[31:0], perf_struct_o[31:0]. Each is a saturating counter incremented on every non-frozen cycle where stall_o=1 and that hazard term is set; several may increment in the same cycle. All three reset to 0.
- Not defined: the ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared package: ALU_WB_LAT/MUL_WB_LAT/BYP_AHEAD defaults, register-index type (5 bits), and the hazard-cause enum {HZ_NONE, HZ_RAW, HZ_WAW, HZ_STRUCT} (also used by the perf counters).
- One natural sub-module, scb_reg_counter: a single per-register countdown with load, decrement, hold and pending flag, instantiated 31 times (r=1..31).

Test Plan:
- Reset: hold rsn_i=0 for 2 cycles, then dec_valid_i=1 ALU rd=5 -> issue_o=1, stall_o=0; next cycle pending_o=0x20, cnt[5]=1.
- MUL rd=3, then ADD rs1=3 -> ADD stall_o=1 for exactly 5 cycles, issue_o=1 on the 6th cycle after the MUL issue.
- MUL rd=4 issued at cycle 0, ALU rd=7 at cycle 5 -> struct stall at cycle 5 (wb_busy[2] set), issue at cycle 6.
- MUL rd=9, then ALU rd=9 at the next cycle -> waw stall until cnt[9]<2, then issue; writebacks to r9 occur in program order.
- Freeze: MUL rd=2 in flight, freeze_i=1 for 4 cycles -> pending_o and wb_busy_o unchanged across the freeze; stall length extends by 4.
- flush_i=1 with a RAW-hazard instruction -> stall_o=0, issue_o=0, state unchanged. With SCB_PERF_EN, a 5-cycle MUL-RAW stall gives perf_raw_o=5.
